// File: rtl/otfs_pkg.sv
// Shared constants and read-FSM encoding for the OTFS ping-pong frame buffer.
package otfs_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_M      = 64;
  localparam int DEF_N      = 16;

  localparam logic RD_MODE_NATURAL   = 1'b0;
  localparam logic RD_MODE_TRANSPOSE = 1'b1;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RUN  = 2'd1,
    RD_LAST = 2'd2
  } rd_state_e;

endpackage

// File: rtl/otfs_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port, registered read (1-cycle latency).
module otfs_sdp_ram #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/otfs_pingpong_ram.sv
// Two-bank OTFS frame buffer: column-major fill, natural or transposed drain through a 2-entry skid.
module otfs_pingpong_ram
  import otfs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int M      = DEF_M,
  parameter int N      = DEF_N
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_frame_done,
  input  logic              rd_transpose,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        bank_full
);

  localparam int AW = $clog2(M*N);
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);

  // write side
  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          wr_fire, wr_end;

  assign wr_ready = !bank_full[wr_bank];
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_end   = wr_fire && (wr_cnt == AW'(M*N-1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_bank       <= 1'b0;
      wr_cnt        <= '0;
      wr_frame_done <= 1'b0;
    end else begin
      wr_frame_done <= wr_end;
      if (wr_end) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // read side
  rd_state_e         st, st_nx;
  logic              rd_bank, mode_q, mode;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic              issue, at_end, pop, rd_done, room;
  logic              inflight, inflight_last;
  logic [1:0]        occ;
  logic [DATA_W-1:0] d0, d1, n_d0, n_d1;
  logic              v0, v1, l0, l1, n_v0, n_v1, n_l0, n_l1;
  logic [1:0][DATA_W-1:0] ram_q;
  logic [1:0]        full_set, full_clr;

  // Mode follows the live input only for the very first address of a frame.
  assign mode    = (st == RD_IDLE) ? rd_transpose : mode_q;
  assign pop     = v0 && rd_ready;
  assign rd_done = pop && l0;
  assign at_end  = (row == RW'(M-1)) && (col == CW'(N-1));
  // Count buffered + in-flight words after this cycle's pop; a new issue needs a free slot.
  assign occ     = 2'(v0) + 2'(v1) + 2'(inflight) - 2'(pop);
  assign room    = (occ <= 2'd1);

  always_comb begin
    st_nx = st;
    issue = 1'b0;
    case (st)
      RD_IDLE: if (bank_full[rd_bank] && room) begin
        issue = 1'b1;
        st_nx = at_end ? RD_LAST : RD_RUN;
      end
      RD_RUN: if (room) begin
        issue = 1'b1;
        if (at_end) st_nx = RD_LAST;
      end
      RD_LAST: if (rd_done) st_nx = RD_IDLE;
      default: st_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (wr_end)  full_set[wr_bank] = 1'b1;
    if (rd_done) full_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st            <= RD_IDLE;
      rd_bank       <= 1'b0;
      mode_q        <= RD_MODE_NATURAL;
      row           <= '0;
      col           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      bank_full     <= 2'b00;
    end else begin
      st            <= st_nx;
      inflight      <= issue;
      inflight_last <= issue && at_end;
      bank_full     <= (bank_full | full_set) & ~full_clr;
      if (st == RD_IDLE && issue) mode_q <= rd_transpose;
      if (rd_done) begin
        rd_bank <= ~rd_bank;
        row     <= '0;
        col     <= '0;
      end else if (issue) begin
        // address is {col,row}; only the fastest-moving counter differs by mode
        if (mode == RD_MODE_NATURAL) begin
          row <= row + 1'b1;
          if (row == RW'(M-1)) col <= col + 1'b1;
        end else begin
          col <= col + 1'b1;
          if (col == CW'(N-1)) row <= row + 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    otfs_sdp_ram #(.DATA_W(DATA_W), .DEPTH(M*N)) u_ram (
      .clk   (Clk),
      .we    (wr_fire && (wr_bank == 1'(b))),
      .waddr (wr_cnt),
      .wdata (wr_data),
      .re    (issue && (rd_bank == 1'(b))),
      .raddr ({col, row}),
      .rdata (ram_q[b])
    );
  end

  // skid buffer: slot 0 is the presented word, slot 1 absorbs the word in flight during a stall
  always_comb begin
    n_d0 = d0; n_l0 = l0; n_v0 = v0;
    n_d1 = d1; n_l1 = l1; n_v1 = v1;
    if (pop) begin
      n_d0 = d1; n_l0 = l1; n_v0 = v1;
      n_v1 = 1'b0; n_l1 = 1'b0;
    end
    if (inflight) begin
      if (!n_v0) begin
        n_d0 = ram_q[rd_bank]; n_l0 = inflight_last; n_v0 = 1'b1;
      end else begin
        n_d1 = ram_q[rd_bank]; n_l1 = inflight_last; n_v1 = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      d0 <= '0; l0 <= 1'b0; v0 <= 1'b0;
      d1 <= '0; l1 <= 1'b0; v1 <= 1'b0;
    end else begin
      d0 <= n_d0; l0 <= n_l0; v0 <= n_v0;
      d1 <= n_d1; l1 <= n_l1; v1 <= n_v1;
    end
  end

  assign rd_valid = v0;
  assign rd_data  = d0;
  assign rd_last  = v0 && l0;

endmodule
